// File: rtl/accu_sum_fifo_pkg.sv
// Shared definitions for consumers of the 4-sample accumulator output:
// default widths and the round-half-up mean used to turn a 4-sample sum into an average.
package accu_sum_fifo_pkg;

    localparam int SUM_W_DEF  = 10;
    localparam int MEAN_W_DEF = SUM_W_DEF - 2;
    localparam int DEPTH_DEF  = 4;

    // Divide a 4-sample sum by four, rounding halves upward; 1020 maps to 255.
    function automatic logic [MEAN_W_DEF-1:0] mean_round(input logic [SUM_W_DEF-1:0] x);
        logic [SUM_W_DEF:0] t;
        t = {1'b0, x} + (SUM_W_DEF+1)'(2);
        return t[MEAN_W_DEF+1:2];
    endfunction

endpackage

// File: rtl/accu_fifo_ctrl.sv
// FIFO bookkeeping for accu_sum_fifo: pointers, occupancy, push/pop qualification
// and the sticky overflow flag for sums that arrive while the FIFO is full.
module accu_fifo_ctrl
    import accu_sum_fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sum_valid,
    input  logic             out_ready,
    input  logic             clr_ovf,
    output logic             push,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty,
    output logic             out_valid,
    output logic             overflow
);

    logic pop;
    logic drop;

    // Status comes from the level counter, so pointer equality is never ambiguous.
    assign full      = (level == LVL_W'(DEPTH));
    assign empty     = (level == '0);
    assign out_valid = !empty;

    // A full FIFO still accepts a sum when the head leaves in the same cycle.
    assign pop  = out_valid && out_ready;
    assign push = sum_valid && (!full || pop);
    assign drop = sum_valid && !push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/accu_sum_fifo.sv
// Buffers pulse-qualified accumulator sums and hands them, with their rounded
// mean, to a consumer over valid/ready.
module accu_sum_fifo
    import accu_sum_fifo_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int SUM_W  = SUM_W_DEF,
    parameter int MEAN_W = SUM_W - 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SUM_W-1:0]         sum_in,
    input  logic                     sum_valid,
    input  logic                     out_ready,
    input  logic                     clr_ovf,
    output logic                     out_valid,
    output logic [SUM_W-1:0]         out_sum,
    output logic [MEAN_W-1:0]        out_mean,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             push;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [SUM_W-1:0] mem [DEPTH];

    accu_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .sum_valid (sum_valid),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .push      (push),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .out_valid (out_valid),
        .overflow  (overflow)
    );

    // Storage carries data only; validity is tracked entirely by the controller.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sum_in;
        end
    end

    assign out_sum = mem[rd_ptr];

    generate
        if (SUM_W == SUM_W_DEF && MEAN_W == MEAN_W_DEF) begin : g_mean_pkg
            assign out_mean = mean_round(out_sum);
        end else begin : g_mean_generic
            logic [SUM_W:0] mean_sum;
            assign mean_sum = {1'b0, out_sum} + (SUM_W+1)'(2);
            assign out_mean = mean_sum[MEAN_W+1:2];
        end
    endgenerate

endmodule

// File: tb/tb_accu_sum_fifo.sv
// Directed and random stimulus for accu_sum_fifo, compared against a queue model.
module tb_accu_sum_fifo;

    localparam int DEPTH  = 4;
    localparam int SUM_W  = 10;
    localparam int MEAN_W = 8;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [SUM_W-1:0]  sum_in;
    logic              sum_valid;
    logic              out_ready;
    logic              clr_ovf;
    logic              out_valid;
    logic [SUM_W-1:0]  out_sum;
    logic [MEAN_W-1:0] out_mean;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    int q[$];
    bit ovf_m;

    accu_sum_fifo #(
        .DEPTH  (DEPTH),
        .SUM_W  (SUM_W),
        .MEAN_W (MEAN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sum_in    (sum_in),
        .sum_valid (sum_valid),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_mean  (out_mean),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_state();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("level", 32'(level), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        if (q.size() != 0) begin
            chk("out_sum", 32'(out_sum), 32'(q[0]));
            chk("out_mean", 32'(out_mean), 32'(((q[0] + 2) / 4) % 256));
        end
    endtask

    // One clock: apply inputs, compare current outputs, advance model, cross the edge.
    task automatic cyc(input bit sv, input int s, input bit rdy, input bit clr);
        bit pop;
        bit push;
        sum_valid = sv;
        sum_in    = SUM_W'(s);
        out_ready = rdy;
        clr_ovf   = clr;
        check_state();
        pop  = (q.size() > 0) && rdy;
        push = sv && ((q.size() < DEPTH) || pop);
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(s);
        if (sv && !push) ovf_m = 1'b1;
        else if (clr)    ovf_m = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int exp_tbl[4];
        rst_n = 1'b0;
        sum_valid = 1'b0;
        sum_in = '0;
        out_ready = 1'b0;
        clr_ovf = 1'b0;
        ovf_m = 1'b0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single capture, hold, then pop
        cyc(1, 513, 0, 0);
        chk("sc_sum", 32'(out_sum), 32'd513);
        chk("sc_mean", 32'(out_mean), 32'd128);
        chk("sc_level", 32'(level), 32'd1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        chk("sc_hold", 32'(out_sum), 32'd513);
        cyc(0, 0, 1, 0);
        chk("sc_empty", 32'(empty), 32'd1);

        // Fill, overflow drop, drain, clear
        for (int i = 1; i <= 4; i++) cyc(1, 100 * i, 0, 0);
        chk("fo_full", 32'(full), 32'd1);
        cyc(1, 500, 0, 0);
        chk("fo_ovf", 32'(overflow), 32'd1);
        chk("fo_level", 32'(level), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("fo_drain", 32'(out_sum), 32'(100 * i));
            chk("fo_mean", 32'(out_mean), 32'(25 * i));
            cyc(0, 0, 1, 0);
        end
        cyc(0, 0, 0, 1);
        chk("fo_clr", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 4; i++) cyc(1, i, 0, 0);
        cyc(1, 1020, 1, 0);
        chk("fp_level", 32'(level), 32'd4);
        chk("fp_ovf", 32'(overflow), 32'd0);
        exp_tbl = '{2, 3, 4, 1020};
        for (int i = 0; i < 4; i++) begin
            chk("fp_drain", 32'(out_sum), 32'(exp_tbl[i]));
            cyc(0, 0, 1, 0);
        end

        // Wrap-around with pass-through traffic
        for (int i = 0; i < 10; i++) begin
            cyc(1, i, 1, 0);
            chk("wr_sum", 32'(out_sum), 32'(i));
            if (i == 6) chk("wr_mean6", 32'(out_mean), 32'd2);
        end
        cyc(0, 0, 1, 0);

        // Back-to-back pushes
        cyc(1, 7, 0, 0);
        cyc(1, 8, 0, 0);
        cyc(1, 9, 0, 0);
        chk("bb_level", 32'(level), 32'd3);
        for (int i = 7; i <= 9; i++) begin
            chk("bb_drain", 32'(out_sum), 32'(i));
            cyc(0, 0, 1, 0);
        end

        // Mid-operation asynchronous reset with three queued sums and overflow set
        for (int i = 1; i <= 5; i++) cyc(1, 40 * i, 0, 0);
        cyc(0, 0, 1, 0);
        chk("mr_pre_level", 32'(level), 32'd3);
        sum_valid = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        ovf_m = 1'b0;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_level", 32'(level), 32'd0);
        chk("mr_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cyc(1, 513, 0, 0);
        chk("mr_sum", 32'(out_sum), 32'd513);
        chk("mr_mean", 32'(out_mean), 32'd128);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, 1020)),
                bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 9) == 0));
        end
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 1, 1);
        check_state();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accu_sum_fifo.md
Name: accu_sum_fifo

Overview:
- Downstream stage of the 4-sample accumulator.
- Captures each 10-bit accumulated sum on its one-cycle valid pulse and buffers it in a small FIFO.
- Presents each sum, plus its rounded 8-bit mean, to a consumer over a valid/ready handshake.
- Decouples the pulse-only accumulator, which has no backpressure, from a stalling consumer, and flags lost sums.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- SUM_W, 10, width of an accumulated sum.
- MEAN_W, 8, width of mean output; equals SUM_W-2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sum_in  in  SUM_W  accumulated sum from accumulator.
- sum_valid  in  1  one-cycle pulse qualifying sum_in.
- out_ready  in  1  consumer ready.
- clr_ovf  in  1  synchronous clear of overflow flag.
- out_valid  out  1  head entry available.
- out_sum  out  SUM_W  head entry sum.
- out_mean  out  MEAN_W  rounded mean of head entry.
- level  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  level==DEPTH.
- empty  out  1  level==0.
- overflow  out  1  sticky: a sum was dropped.

Behaviour:
- Reset (async, rst_n low): wr_ptr=0, rd_ptr=0, level=0, overflow=0, so out_valid=0, empty=1, full=0. Storage array is not reset; out_sum and out_mean are don't-care while out_valid=0 (bench must not check them).
- push = sum_valid && (!full || pop).
- pop = out_valid && out_ready.
- Push: stores sum_in at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH.
- level: +1 on push-only, -1 on pop-only, unchanged on both or neither.
- Latency: a sum pushed at edge N gives out_valid=1 in the cycle after edge N. No same-cycle bypass when empty.
- Outputs are combinational from the registered head entry and level:
  - out_valid = !empty.
  - out_sum = mem[rd_ptr].
  - out_mean = (out_sum + 2) >> 2, truncated to MEAN_W. Maximum sum 1020 gives 255, so no saturation is needed.
- Handshake: out_sum and out_valid stay stable while out_valid=1 and out_ready=0. out_ready while empty has no effect.
- Full with sum_valid and pop in the same cycle: push is accepted, level stays DEPTH, no overflow.
- Full with sum_valid and no pop: sum is dropped, overflow<=1, FIFO contents and pointers unchanged.
- overflow stays set until clr_ovf=1. If clr_ovf and a drop occur in the same cycle, the set wins (overflow=1).
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. full and empty are derived from level, not from pointer compare.
- sum_valid held high for consecutive cycles: each cycle is a separate push. The block does not assume pulse spacing.
- Reset asserted mid-operation: all queued sums are discarded immediately. Output state is as at reset on the next cycle after release.

Decomposition:
- Shared package holds:
  - SUM_W and MEAN_W defaults.
  - A mean_round function, (x+2)>>2, reused by any later consumer of accumulator output.
- One natural sub-module, accu_fifo_ctrl: owns pointers, level, push/pop qualification, full/empty and overflow.
- The top holds the storage array and the mean computation.

Test Plan:
- Single capture: reset, pulse sum_valid with sum_in=10'd513, out_ready=0. Next cycle: out_valid=1, out_sum=513, out_mean=128, level=1. Hold 5 cycles, values stable. Raise out_ready: popped after one cycle, empty=1.
- Fill and overflow (DEPTH=4): push 100, 200, 300, 400 with out_ready=0, giving full=1. Push 500: dropped, overflow=1, level=4. Drain gives 100, 200, 300, 400 in order with means 25, 50, 75, 100. Pulse clr_ovf: overflow=0.
- Full with simultaneous push/pop: fill with 1, 2, 3, 4; same cycle sum_valid with 1020 and out_ready=1. Result: level=4, overflow=0. Drain order 2, 3, 4, 1020; last mean=255.
- Wrap-around: 10 push/pop pairs with sums 0..9 at out_ready=1. Every sum appears in order one cycle after push; level never exceeds 1; mean of 6 is 2 (round-half-up check: (6+2)>>2=2).
- Back-to-back: sum_valid high 3 consecutive cycles with 7, 8, 9 and out_ready=0. Result: level=3; drain 7, 8, 9.
- Mid-operation reset: with level=3, assert rst_n=0 asynchronously between edges. Immediately: out_valid=0, level=0, overflow=0. After release the next push behaves as in the single-capture scenario.
